// File: rtl/clk_switch_pkg.sv
// ============================================================================
// Module      : clk_switch_pkg
// Description : Shared FSM state type, clock source encodings and helpers for
//               the clock-switch controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_switch_pkg;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_WAIT_OFF = 3'd2,
    ST_WAIT_ON  = 3'd3,
    ST_ERR      = 3'd4
  } clk_sw_state_t;

  localparam logic SRC_CLK0 = 1'b0;
  localparam logic SRC_CLK1 = 1'b1;

  // Synced gate-enable of the given source.
  function automatic logic pick_en(input logic src, input logic en0, input logic en1);
    return (src == SRC_CLK1) ? en1 : en0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_ff_chain.sv
// ============================================================================
// Module      : sync_ff_chain
// Description : Single-bit multi-flop synchronizer, async active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_ff_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/clk_switch_ctrl.sv
// ============================================================================
// Module      : clk_switch_ctrl
// Description : Handshake controller for a glitch-free clock mux; confirms
//               each switch via synchronized branch enables. Optional wait
//               timeout enabled by defining CLK_SWITCH_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_switch_ctrl
  import clk_switch_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  output logic sel,
  input  logic en0_async,
  input  logic en1_async,
  output logic cur_sel,
  output logic busy,
  output logic done,
  output logic err,
  output logic err_sticky,
  input  logic err_clr
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("clk_switch_ctrl: parameter out of range");
  end

  logic en0_s;
  logic en1_s;

  sync_ff_chain #(.STAGES(SYNC_STAGES)) u_sync_en0 (
    .clk (clk),
    .rst (rst),
    .d   (en0_async),
    .q   (en0_s)
  );

  sync_ff_chain #(.STAGES(SYNC_STAGES)) u_sync_en1 (
    .clk (clk),
    .rst (rst),
    .d   (en1_async),
    .q   (en1_s)
  );

  clk_sw_state_t state_q, state_d;
  logic          sel_q, sel_d;
  logic          cur_sel_q, cur_sel_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          err_sticky_q, err_sticky_d;

  logic overlap;
  logic old_en;
  logic new_en;
  logic exit_cond;
  logic timeout_hit;

  assign overlap = en0_s & en1_s;
  assign old_en  = pick_en(cur_sel_q, en0_s, en1_s);
  assign new_en  = pick_en(sel_q, en0_s, en1_s);

  always_comb begin
    exit_cond = 1'b0;
    case (state_q)
      ST_INIT:     exit_cond = en0_s;
      ST_WAIT_OFF: exit_cond = !old_en;
      ST_WAIT_ON:  exit_cond = new_en;
      default:     exit_cond = 1'b0;
    endcase
  end

`ifdef CLK_SWITCH_TIMEOUT_EN
  localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wait_next;

  assign wait_next   = (state_d == ST_INIT) || (state_d == ST_WAIT_OFF) || (state_d == ST_WAIT_ON);
  assign timeout_hit = ((state_q == ST_INIT) || (state_q == ST_WAIT_OFF) || (state_q == ST_WAIT_ON))
                       && !exit_cond && (cnt_q == CNT_ONE);

  // A zero count while waiting only occurs right after reset; treat it as entry.
  always_comb begin
    cnt_d = cnt_q;
    if (wait_next) begin
      if ((state_d != state_q) || (cnt_q == '0)) begin
        cnt_d = CNT_LOAD;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_INIT;
      sel_q        <= SRC_CLK0;
      cur_sel_q    <= SRC_CLK0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      cur_sel_q    <= cur_sel_d;
      done_q       <= done_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cur_sel_d = cur_sel_q;
    done_d    = 1'b0;

    case (state_q)
      ST_INIT: begin
        sel_d = SRC_CLK0;
        if (exit_cond) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (req_valid) begin
          if (req_sel == cur_sel_q) begin
            done_d = 1'b1;
          end else begin
            sel_d   = req_sel;
            state_d = ST_WAIT_OFF;
          end
        end
      end
      ST_WAIT_OFF: begin
        if (exit_cond) state_d = ST_WAIT_ON;
      end
      ST_WAIT_ON: begin
        if (exit_cond) begin
          cur_sel_d = sel_q;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_ERR: begin
        sel_d = cur_sel_q;
        if (err_clr) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    // Overlap beats everything, including an err_clr in ERR.
    if (overlap || timeout_hit) begin
      state_d   = ST_ERR;
      sel_d     = cur_sel_q;
      cur_sel_d = cur_sel_q;
      done_d    = 1'b0;
    end

    err_d        = (state_d == ST_ERR) && (state_q != ST_ERR);
    err_sticky_d = err_clr ? 1'b0 : err_sticky_q;
    if (state_d == ST_ERR) err_sticky_d = 1'b1;
  end

  // Output logic
  always_comb begin
    req_ready = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
  end

  assign sel        = sel_q;
  assign cur_sel    = cur_sel_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_sticky = err_sticky_q;

endmodule

`default_nettype wire

// File: tb/tb_clk_switch_ctrl.sv
// ============================================================================
// Module      : tb_clk_switch_ctrl
// Description : Self-checking bench for clk_switch_ctrl with randomized switch
//               timing against a latency model. Define CLK_SWITCH_TIMEOUT_EN
//               to exercise the timeout build.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_switch_ctrl;

  localparam int SS = 2;
`ifdef CLK_SWITCH_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_sel = 1'b0;
  logic en0_async = 1'b0;
  logic en1_async = 1'b0;
  logic err_clr = 1'b0;
  logic req_ready, sel, cur_sel, busy, done, err, err_sticky;

  int   n_checks = 0;
  int   n_pass = 0;
  logic m_cur = 1'b0;

  always #5 clk = ~clk;

  clk_switch_ctrl #(.SYNC_STAGES(SS), .TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_sel    (req_sel),
    .req_ready  (req_ready),
    .sel        (sel),
    .en0_async  (en0_async),
    .en1_async  (en1_async),
    .cur_sel    (cur_sel),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_sticky (err_sticky),
    .err_clr    (err_clr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_en(input logic src, input logic v);
    if (src) en1_async = v;
    else     en0_async = v;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; req_valid = 1'b0; err_clr = 1'b0; en0_async = 1'b0; en1_async = 1'b0;
    repeat (2) step();
    n_checks++; if ({sel, cur_sel, done, err, err_sticky} !== 5'b0) $display("FAIL reset_outs: got %b exp 00000", {sel, cur_sel, done, err, err_sticky}); else n_pass++;
    n_checks++; if ({busy, req_ready} !== 2'b10) $display("FAIL reset_busy_ready: got %b exp 10", {busy, req_ready}); else n_pass++;
    rst = 1'b0;
    repeat (3) step();
    n_checks++; if (req_ready !== 1'b0) $display("FAIL init_ready: got %b exp 0", req_ready); else n_pass++;
    en0_async = 1'b1;
    n = 0;
    while (n < 20 && req_ready !== 1'b1) begin step(); n++; end
    n_checks++; if (n != SS + 1) $display("FAIL init_latency: got %0d exp %0d", n, SS + 1); else n_pass++;
    n_checks++; if ({cur_sel, sel, busy} !== 3'b000) $display("FAIL idle_outs: got %b exp 000", {cur_sel, sel, busy}); else n_pass++;
    m_cur = 1'b0;
  endtask

  task automatic test_same_sel();
    req_valid = 1'b1; req_sel = m_cur;
    step();
    req_valid = 1'b0;
    n_checks++; if ({done, sel, busy, req_ready} !== {1'b1, m_cur, 1'b0, 1'b1}) $display("FAIL same_sel_pulse: got %b exp %b", {done, sel, busy, req_ready}, {1'b1, m_cur, 1'b0, 1'b1}); else n_pass++;
    step();
    n_checks++; if ({done, sel} !== {1'b0, m_cur}) $display("FAIL same_sel_after: got %b exp %b", {done, sel}, {1'b0, m_cur}); else n_pass++;
  endtask

  // Mux model: old enable drops d1 cycles after accept, new one rises d2 later.
  task automatic test_switch(input int d1, input int d2);
    logic nw, old;
    int n_exp, done_cnt, done_at, sel_bad, busy_bad, cur_bad;
    old = m_cur; nw = ~m_cur;
    n_exp = d1 + d2 + SS + 1;
    done_cnt = 0; done_at = -1; sel_bad = 0; busy_bad = 0; cur_bad = 0;
    req_valid = 1'b1; req_sel = nw;
    for (int n = 0; n <= n_exp + 3; n++) begin
      step();
      if (done === 1'b1) begin done_cnt++; done_at = n; end
      if (sel !== nw) sel_bad++;
      if (n < n_exp && busy !== 1'b1) busy_bad++;
      if (n < n_exp && cur_sel !== old) cur_bad++;
      if (n == d1) set_en(old, 1'b0);
      if (n == d1 + d2) set_en(nw, 1'b1);
      req_valid = (n < n_exp) ? 1'($urandom_range(0, 1)) : 1'b0;
      req_sel   = 1'($urandom_range(0, 1));
    end
    req_valid = 1'b0;
    n_checks++; if (done_cnt != 1 || done_at != n_exp) $display("FAIL switch_done: got count %0d at %0d exp 1 at %0d", done_cnt, done_at, n_exp); else n_pass++;
    n_checks++; if (sel_bad != 0) $display("FAIL switch_sel: got %0d bad cycles exp 0", sel_bad); else n_pass++;
    n_checks++; if (busy_bad != 0 || cur_bad != 0) $display("FAIL switch_busy_cur: got %0d/%0d bad cycles exp 0/0", busy_bad, cur_bad); else n_pass++;
    n_checks++; if ({cur_sel, busy, err_sticky} !== {nw, 1'b0, 1'b0}) $display("FAIL switch_end: got %b exp %b", {cur_sel, busy, err_sticky}, {nw, 1'b0, 1'b0}); else n_pass++;
    m_cur = nw;
  endtask

  task automatic test_back_to_back();
    logic nw;
    int dones, n;
    nw = ~m_cur; dones = 0;
    req_valid = 1'b1; req_sel = m_cur;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done === 1'b1) dones++;
    end
    n_checks++; if (dones != 3) $display("FAIL b2b_dones: got %0d exp 3", dones); else n_pass++;
    req_sel = nw;
    step();
    req_valid = 1'b0;
    n_checks++; if ({sel, busy, done} !== {nw, 1'b1, 1'b0}) $display("FAIL b2b_accept: got %b exp %b", {sel, busy, done}, {nw, 1'b1, 1'b0}); else n_pass++;
    set_en(m_cur, 1'b0);
    repeat (SS + 2) step();
    set_en(nw, 1'b1);
    n = 0;
    while (n < 20 && done !== 1'b1) begin step(); n++; end
    n_checks++; if (done !== 1'b1 || cur_sel !== nw) $display("FAIL b2b_complete: got done %b cur %b exp 1 %b", done, cur_sel, nw); else n_pass++;
    m_cur = nw;
  endtask

  task automatic test_overlap();
    logic other;
    int err_at, err_cnt;
    other = ~m_cur; err_at = -1; err_cnt = 0;
    set_en(other, 1'b1);
    for (int n = 1; n <= SS + 4; n++) begin
      step();
      if (err === 1'b1) begin err_cnt++; err_at = n; end
    end
    n_checks++; if (err_cnt != 1 || err_at != SS + 1) $display("FAIL overlap_err: got count %0d at %0d exp 1 at %0d", err_cnt, err_at, SS + 1); else n_pass++;
    n_checks++; if ({req_ready, busy, err_sticky, sel, cur_sel} !== {3'b011, m_cur, m_cur}) $display("FAIL overlap_state: got %b exp %b", {req_ready, busy, err_sticky, sel, cur_sel}, {3'b011, m_cur, m_cur}); else n_pass++;
    err_clr = 1'b1; step(); err_clr = 1'b0;
    n_checks++; if (req_ready !== 1'b0) $display("FAIL overlap_priority: got ready %b exp 0", req_ready); else n_pass++;
    set_en(other, 1'b0);
    repeat (SS + 2) step();
    n_checks++; if (req_ready !== 1'b0) $display("FAIL err_hold: got ready %b exp 0", req_ready); else n_pass++;
    err_clr = 1'b1; step(); err_clr = 1'b0;
    n_checks++; if ({req_ready, err_sticky, err} !== 3'b100) $display("FAIL err_clear: got %b exp 100", {req_ready, err_sticky, err}); else n_pass++;
  endtask

  task automatic test_bad_switch();
    logic nw, old;
    int err_at;
    old = m_cur; nw = ~m_cur; err_at = -1;
    req_valid = 1'b1; req_sel = nw;
    step();
    req_valid = 1'b0;
    n_checks++; if (sel !== nw) $display("FAIL bad_sw_sel: got %b exp %b", sel, nw); else n_pass++;
    for (int n = 1; n <= SS + 6; n++) begin
      step();
      if (err === 1'b1 && err_at < 0) err_at = n;
      if (n == 2) set_en(nw, 1'b1);
    end
    n_checks++; if (err_at != SS + 3) $display("FAIL bad_sw_err: got %0d exp %0d", err_at, SS + 3); else n_pass++;
    n_checks++; if ({sel, cur_sel, err_sticky} !== {old, old, 1'b1}) $display("FAIL bad_sw_revert: got %b exp %b", {sel, cur_sel, err_sticky}, {old, old, 1'b1}); else n_pass++;
    set_en(nw, 1'b0);
    repeat (SS + 2) step();
    err_clr = 1'b1; step(); err_clr = 1'b0;
    n_checks++; if ({req_ready, err_sticky} !== 2'b10) $display("FAIL bad_sw_clear: got %b exp 10", {req_ready, err_sticky}); else n_pass++;
  endtask

`ifdef CLK_SWITCH_TIMEOUT_EN
  task automatic test_timeout();
    logic nw, old;
    int err_at;
    old = m_cur; nw = ~m_cur; err_at = -1;
    req_valid = 1'b1; req_sel = nw;
    for (int n = 0; n <= TO + 4; n++) begin
      step();
      req_valid = 1'b0;
      if (err === 1'b1 && err_at < 0) err_at = n;
    end
    n_checks++; if (err_at != TO) $display("FAIL timeout_err: got %0d exp %0d", err_at, TO); else n_pass++;
    n_checks++; if ({sel, err_sticky, req_ready} !== {old, 2'b10}) $display("FAIL timeout_state: got %b exp %b", {sel, err_sticky, req_ready}, {old, 2'b10}); else n_pass++;
    err_clr = 1'b1; step(); err_clr = 1'b0;
    n_checks++; if ({req_ready, err_sticky} !== 2'b10) $display("FAIL timeout_clear: got %b exp 10", {req_ready, err_sticky}); else n_pass++;
  endtask
`else
  task automatic test_no_timeout();
    logic nw, old;
    int errs, n;
    old = m_cur; nw = ~m_cur; errs = 0;
    req_valid = 1'b1; req_sel = nw;
    for (int i = 0; i < 60; i++) begin
      step();
      req_valid = 1'b0;
      if (err === 1'b1) errs++;
    end
    n_checks++; if (errs != 0 || busy !== 1'b1 || sel !== nw) $display("FAIL no_timeout: got errs %0d busy %b sel %b exp 0 1 %b", errs, busy, sel, nw); else n_pass++;
    set_en(old, 1'b0);
    repeat (2) step();
    set_en(nw, 1'b1);
    n = 0;
    while (n < 20 && done !== 1'b1) begin step(); n++; end
    n_checks++; if (done !== 1'b1 || cur_sel !== nw) $display("FAIL no_timeout_done: got done %b cur %b exp 1 %b", done, cur_sel, nw); else n_pass++;
    m_cur = nw;
  endtask
`endif

  task automatic test_reset_mid_switch();
    int dones;
    dones = 0;
    req_valid = 1'b1; req_sel = ~m_cur;
    step();
    req_valid = 1'b0;
    step();
    set_en(m_cur, 1'b0);
    repeat (SS + 3) step();
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if ({sel, cur_sel, done, err, err_sticky, busy, req_ready} !== 7'b0000010) $display("FAIL rst_mid: got %b exp 0000010", {sel, cur_sel, done, err, err_sticky, busy, req_ready}); else n_pass++;
    set_en(~m_cur, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      if (done === 1'b1) dones++;
    end
    n_checks++; if (dones != 0) $display("FAIL rst_mid_done: got %0d exp 0", dones); else n_pass++;
    test_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_same_sel();
    for (int i = 0; i < 6; i++) begin
      test_switch(int'($urandom_range(1, 6)), int'($urandom_range(1, 6)));
      test_same_sel();
    end
    test_back_to_back();
    test_overlap();
    test_bad_switch();
`ifdef CLK_SWITCH_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid_switch();
    test_switch(int'($urandom_range(1, 6)), int'($urandom_range(1, 6)));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/clk_switch_ctrl.md
CLK_SWITCH_CTRL -- requirements
Module: clk_switch_ctrl

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on each mux-status input (legal range 2..4).
REQ-002 Parameter TIMEOUT_CYC, default 1024, clk cycles allowed per wait state before error; counter width is $clog2(TIMEOUT_CYC+1).
REQ-003 clk  input  1  free-running always-on reference clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req_valid  input  1  switch request valid.
REQ-006 req_sel  input  1  requested source: 0 = clk0, 1 = clk1.
REQ-007 req_ready  output  1  high only in IDLE; request accepted when req_valid && req_ready.
REQ-008 sel  output  1  select driven to the glitch-free clock mux.
REQ-009 en0_async, en1_async  input  1 each  gate-enable status of mux branch 0/1, asynchronous to clk.
REQ-010 cur_sel  output  1  confirmed active source.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse on completed (or no-op) request.
REQ-013 err  output  1  one-cycle pulse on error entry; err_sticky  output  1  held until err_clr.
REQ-014 err_clr  input  1  single-cycle clear of ERR state and err_sticky.

Function
REQ-015 en0_async/en1_async SHALL each pass through a SYNC_STAGES flop chain (reset 0); all decisions use synced values en0_s/en1_s.
REQ-016 FSM states SHALL be INIT, IDLE, WAIT_OFF, WAIT_ON, ERR.
REQ-017 INIT: sel=0; go to IDLE when en0_s=1; cur_sel stays 0.
REQ-018 IDLE: on accept with req_sel==cur_sel, SHALL pulse done next cycle, remain IDLE, sel unchanged.
REQ-019 IDLE: on accept with req_sel!=cur_sel, SHALL set sel=req_sel next cycle and enter WAIT_OFF.
REQ-020 WAIT_OFF: SHALL go to WAIT_ON when synced enable of the old source (cur_sel) reads 0.
REQ-021 WAIT_ON: when synced enable of sel reads 1, SHALL set cur_sel=sel, pulse done, enter IDLE in the same edge.
REQ-022 en0_s && en1_s both 1 in any state SHALL pulse err and enter ERR (overlap violation, always checked, has priority over every other transition).
REQ-023 ERR: req_ready=0; sel SHALL revert to cur_sel; on err_clr go to IDLE and clear err_sticky; err_clr outside ERR clears err_sticky only.
REQ-024 req_valid outside IDLE SHALL be ignored (not queued); requester must hold req_valid until ready.
REQ-025 Done-to-next-accept latency minimum 1 cycle (IDLE re-entry then accept).

Reset
REQ-026 On rst: state INIT, sel=0, cur_sel=0, done=0, err=0, err_sticky=0, timeout counter=0, sync flops=0; busy=1, req_ready=0.
REQ-027 rst asserted mid-switch SHALL abort immediately to the above values; no done pulse generated.

Configuration
REQ-028 Macro CLK_SWITCH_TIMEOUT_EN: when defined, counter loads TIMEOUT_CYC on entry to INIT/WAIT_OFF/WAIT_ON, decrements each cycle there; reaching 0 before exit SHALL pulse err and enter ERR.
REQ-029 Without CLK_SWITCH_TIMEOUT_EN: no counter is instantiated, wait states wait indefinitely, only REQ-022 produces err.

Structure
REQ-030 Package clk_switch_pkg SHALL hold the FSM state enum (typedef clk_sw_state_t) and source encoding constants SRC_CLK0=1'b0, SRC_CLK1=1'b1.
REQ-031 Sub-module sync_ff_chain (parameter STAGES, 1-bit, async active-high reset) SHALL be instantiated once per status input.

Verification
REQ-032 Reset release, en0_async=1 after 3 cycles -> IDLE reached at cycle 3+SYNC_STAGES+1, req_ready=1, cur_sel=0, sel=0.
REQ-033 In IDLE request req_sel=1; model drops en0 after 4 cycles, raises en1 4 cycles later -> sel=1 next cycle, done single pulse, cur_sel=1, busy low after done.
REQ-034 Request req_sel=0 while cur_sel=0 -> done pulse next cycle, sel never toggles, busy stays 0.
REQ-035 With CLK_SWITCH_TIMEOUT_EN, TIMEOUT_CYC=16, request switch and never drop old enable -> err pulse after 16 cycles in WAIT_OFF, sel reverts, err_sticky=1; err_clr -> IDLE, err_sticky=0.
REQ-036 Force en0_async=en1_async=1 in IDLE -> err within SYNC_STAGES+1 cycles, ERR state, req_ready=0.
REQ-037 Assert rst during WAIT_ON -> all outputs at REQ-026 values within same cycle, no done pulse.
